// File: rtl/pc_pkg.sv
// Shared program-counter types and constants for the fetch, decode and branch-target logic.
package pc_pkg;

   localparam int PC_W = 11;

   typedef logic [PC_W-1:0] pc_t;

   // Word-addressed fetch: one step per instruction.
   localparam pc_t PC_STEP  = pc_t'(1);
   localparam pc_t RESET_PC = pc_t'(0);

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: sequential incrementer plus the branch/sequential 2:1 mux.
module pc_next_sel
   import pc_pkg::*;
(
   input  logic [PC_W-1:0] pc,
   input  logic [PC_W-1:0] br_pc,
   input  logic            pc_sel,
   output logic [PC_W-1:0] add_pc,
   output logic [PC_W-1:0] npc
);

   // Sum is truncated to PC_W bits, so the all-ones address wraps to zero.
   always_comb begin
      add_pc = pc + PC_STEP;
      npc    = pc_sel ? br_pc : add_pc;
   end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter register with async active-low reset.
// Optional hold input enabled by defining PC_STALL_EN.
module pc_unit
   import pc_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
`ifdef PC_STALL_EN
   input  logic            stall,
`endif
   input  logic            branch_alu,
   input  logic            branch_control,
   input  logic [PC_W-1:0] br_pc,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] add_pc,
   output logic [PC_W-1:0] npc,
   output logic            pc_sel
);

   pc_t pc_q;

   assign pc_sel = branch_control & branch_alu;
   assign pc     = pc_q;

   pc_next_sel u_next_sel (
      .pc     (pc_q),
      .br_pc  (br_pc),
      .pc_sel (pc_sel),
      .add_pc (add_pc),
      .npc    (npc)
   );

   // Reset wins over stall and over any pending branch or increment.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q <= RESET_PC;
      end
`ifdef PC_STALL_EN
      else if (!stall) begin
         pc_q <= npc;
      end
`else
      else begin
         pc_q <= npc;
      end
`endif
   end

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit; covers the stall hold when PC_STALL_EN is defined.
module tb_pc_unit;

   logic        clk;
   logic        reset;
   logic        branch_alu;
   logic        branch_control;
   logic [10:0] br_pc;
   logic [10:0] pc;
   logic [10:0] add_pc;
   logic [10:0] npc;
   logic        pc_sel;
`ifdef PC_STALL_EN
   logic        stall;
`endif

   int checks   = 0;
   int failures = 0;

   pc_unit dut (
      .clk            (clk),
      .reset          (reset),
`ifdef PC_STALL_EN
      .stall          (stall),
`endif
      .branch_alu     (branch_alu),
      .branch_control (branch_control),
      .br_pc          (br_pc),
      .pc             (pc),
      .add_pc         (add_pc),
      .npc            (npc),
      .pc_sel         (pc_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [10:0] observed, input logic [10:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic bc, input logic ba, input logic [10:0] target);
      branch_control = bc;
      branch_alu     = ba;
      br_pc          = target;
   endtask

   // Advance one rising edge and settle just past it.
   task automatic stepEdge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
`ifdef PC_STALL_EN
      stall = 1'b0;
`endif
      applyStimulus(1'b0, 1'b0, 11'h000);
      #2;
      checkOutput("reset_pc", pc, 11'h000);
      checkOutput("reset_add_pc", add_pc, 11'h001);
      checkOutput("reset_pc_sel", {10'b0, pc_sel}, 11'h000);

      // Reset held low across an edge keeps pc at the reset value.
      stepEdge();
      checkOutput("reset_hold", pc, 11'h000);

      reset = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         stepEdge();
         checkOutput($sformatf("seq_pc_%0d", i), pc, 11'(i));
         checkOutput($sformatf("seq_add_%0d", i), add_pc, 11'(i + 1));
      end

      // Asynchronous reset between edges.
      reset = 1'b0;
      #1;
      checkOutput("async_reset_pc", pc, 11'h000);
      checkOutput("async_reset_add", add_pc, 11'h001);
      reset = 1'b1;
      for (int i = 1; i <= 4; i++) stepEdge();
      checkOutput("pre_branch_pc", pc, 11'h004);

      // Taken branch.
      applyStimulus(1'b1, 1'b1, 11'h155);
      #1;
      checkOutput("taken_pc_sel", {10'b0, pc_sel}, 11'h001);
      checkOutput("taken_npc", npc, 11'h155);
      stepEdge();
      checkOutput("taken_pc", pc, 11'h155);
      applyStimulus(1'b0, 1'b0, 11'h155);
      stepEdge();
      checkOutput("after_taken_pc", pc, 11'h156);

      // Only one branch qualifier high: sequential fetch.
      applyStimulus(1'b1, 1'b0, 11'h0AA);
      #1;
      checkOutput("nt_ctl_pc_sel", {10'b0, pc_sel}, 11'h000);
      checkOutput("nt_ctl_npc", npc, 11'h157);
      stepEdge();
      checkOutput("nt_ctl_pc", pc, 11'h157);
      applyStimulus(1'b0, 1'b1, 11'h0AA);
      #1;
      checkOutput("nt_alu_pc_sel", {10'b0, pc_sel}, 11'h000);
      stepEdge();
      checkOutput("nt_alu_pc", pc, 11'h158);

      // Wraparound from the all-ones address.
      applyStimulus(1'b1, 1'b1, 11'h7FF);
      stepEdge();
      checkOutput("wrap_branch_pc", pc, 11'h7FF);
      applyStimulus(1'b0, 1'b0, 11'h000);
      #1;
      checkOutput("wrap_add_pc", add_pc, 11'h000);
      checkOutput("wrap_npc", npc, 11'h000);
      stepEdge();
      checkOutput("wrap_pc", pc, 11'h000);
      stepEdge();
      checkOutput("wrap_next_pc", pc, 11'h001);

      // Reset asserted with a taken branch pending overrides it.
      applyStimulus(1'b1, 1'b1, 11'h321);
      reset = 1'b0;
      stepEdge();
      checkOutput("reset_over_branch", pc, 11'h000);
      applyStimulus(1'b0, 1'b0, 11'h000);
      reset = 1'b1;
      stepEdge();
      checkOutput("post_reset_pc", pc, 11'h001);

`ifdef PC_STALL_EN
      for (int i = 2; i <= 7; i++) stepEdge();
      checkOutput("stall_start_pc", pc, 11'h007);
      applyStimulus(1'b1, 1'b1, 11'h123);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         stepEdge();
         checkOutput($sformatf("stall_hold_%0d", i), pc, 11'h007);
         checkOutput($sformatf("stall_npc_%0d", i), npc, 11'h123);
      end
      stall = 1'b0;
      stepEdge();
      checkOutput("stall_release_pc", pc, 11'h123);
      // Reset overrides stall.
      stall = 1'b1;
      reset = 1'b0;
      #1;
      checkOutput("reset_over_stall", pc, 11'h000);
      reset = 1'b1;
      stall = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
